// File: rtl/rv32i_mem_arbiter.sv
// Arbiter sharing one single-port memory bus between the rv32i instruction and data ports.
// Each port owns a one-deep request slot. Its busy flag is the slot-valid bit.
module rv32i_mem_arbiter #(
  parameter bit D_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_rstrb,
  output logic [31:0] i_rdata,
  output logic        i_rbusy,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  input  logic        d_wstrb,
  input  logic        d_rstrb,
  output logic [31:0] d_rdata,
  output logic        d_rbusy,
  output logic        d_wbusy,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  output logic        m_wstrb,
  output logic        m_rstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state;
  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  logic [3:0]  d_wmask_q;
  logic        cur_d, rr_last_i;
  logic        d_pend, other_pend, launch, grant_d, grant_wr;

  always_comb begin
    d_pend     = d_rbusy | d_wbusy;
    other_pend = cur_d ? i_rbusy : d_pend;
    launch     = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        launch  = i_rbusy | d_pend;
        grant_d = d_pend & (~i_rbusy | D_PRIO | rr_last_i);
      end
      // Completion cycle hands the bus straight to the other slot
      WAIT: begin
        launch  = ~m_busy & other_pend;
        grant_d = ~cur_d;
      end
      default: ;
    endcase
    grant_wr = grant_d & d_wbusy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_wmask_q <= '0;
      cur_d     <= 1'b0;
      rr_last_i <= 1'b0;
      i_rdata   <= '0;
      i_rbusy   <= 1'b0;
      d_rdata   <= '0;
      d_rbusy   <= 1'b0;
      d_wbusy   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wmask   <= '0;
      m_wstrb   <= 1'b0;
      m_rstrb   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      m_rstrb <= 1'b0;
      m_wstrb <= 1'b0;

      if (i_rstrb) begin
        if (i_rbusy) begin
          proto_err <= 1'b1;
        end else begin
          i_rbusy  <= 1'b1;
          i_addr_q <= i_addr;
        end
      end

      // A combined read+write strobe keeps only the write
      if (d_wstrb | d_rstrb) begin
        if (d_pend) begin
          proto_err <= 1'b1;
        end else begin
          d_addr_q  <= d_addr;
          d_wdata_q <= d_wdata;
          d_wmask_q <= d_wmask;
          d_wbusy   <= d_wstrb;
          d_rbusy   <= ~d_wstrb;
          if (d_wstrb & d_rstrb) proto_err <= 1'b1;
        end
      end

      case (state)
        IDLE:  if (launch) state <= ISSUE;
        ISSUE: state <= WAIT;
        WAIT: begin
          if (!m_busy) begin
            if (cur_d) begin
              if (d_rbusy) d_rdata <= m_rdata;
              d_rbusy <= 1'b0;
              d_wbusy <= 1'b0;
            end else begin
              i_rdata <= m_rdata;
              i_rbusy <= 1'b0;
            end
            state <= launch ? ISSUE : IDLE;
            if (!launch) begin
              m_addr  <= '0;
              m_wdata <= '0;
              m_wmask <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (launch) begin
        cur_d     <= grant_d;
        rr_last_i <= ~grant_d;
        m_addr    <= grant_d ? d_addr_q : i_addr_q;
        m_wdata   <= grant_wr ? d_wdata_q : '0;
        m_wmask   <= grant_wr ? d_wmask_q : '0;
        m_wstrb   <= grant_wr;
        m_rstrb   <= ~grant_wr;
      end
    end
  end

endmodule
